// File: rtl/ext_pipe_unit.sv
// Immediate-extend stage: sign/zero extension into a 2-entry elastic buffer.
// Optional EXT_SHIFT_EN adds in_shift for a word-to-byte (<<2) offset.
module ext_pipe_unit #(
  parameter int INSIZE_A = 19,
  parameter int INSIZE_B = 23,
  parameter int OUTSIZE  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSIZE_B-1:0] in_data,
  input  logic [1:0]          in_mode,
`ifdef EXT_SHIFT_EN
  input  logic                in_shift,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTSIZE-1:0]  out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUTSIZE-1:0] head_q, head_d;
  logic [OUTSIZE-1:0] skid_q, skid_d;

  logic               push, pop;
  logic [OUTSIZE-1:0] ext_a_s, ext_a_z;
  logic [OUTSIZE-1:0] ext_b_s, ext_b_z;
  logic [OUTSIZE-1:0] ext;
  logic [OUTSIZE-1:0] ext_res;

  assign ext_a_s = {{(OUTSIZE-INSIZE_A){in_data[INSIZE_A-1]}},
                    in_data[INSIZE_A-1:0]};
  assign ext_a_z = {{(OUTSIZE-INSIZE_A){1'b0}},
                    in_data[INSIZE_A-1:0]};
  assign ext_b_s = {{(OUTSIZE-INSIZE_B){in_data[INSIZE_B-1]}},
                    in_data};
  assign ext_b_z = {{(OUTSIZE-INSIZE_B){1'b0}},
                    in_data};

  always_comb begin
    ext = ext_a_s;
    unique case (in_mode)
      2'b00:   ext = ext_a_s;
      2'b01:   ext = ext_b_s;
      2'b10:   ext = ext_a_z;
      default: ext = ext_b_z;
    endcase
  end

`ifdef EXT_SHIFT_EN
  assign ext_res = in_shift ? {ext[OUTSIZE-3:0], 2'b00} : ext;
`else
  assign ext_res = ext;
`endif

  // Ready comes from registered state only, never from out_ready.
  assign in_ready  = !reset && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = ext_res;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = ext_res;
        end else if (push) begin
          state_d = TWO;
          skid_d  = ext_res;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Scoreboard bench for ext_pipe_unit: driver queues expected
// results, a negedge monitor pops and compares on every pop.
module tb_ext_pipe_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        in_shift = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  ext_pipe_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
`ifdef EXT_SHIFT_EN
    .in_shift  (in_shift),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: pick field width, mask, sign-adjust as an integer,
  // optionally multiply by 4, then wrap to 32 bits.
  function automatic logic [31:0] model(input logic [22:0] d,
                                        input logic [1:0] m,
                                        input logic sh);
    longint w, v;
    w = m[0] ? 23 : 19;
    v = longint'(d) % (64'sd1 <<< w);
    if (!m[1] && v >= (64'sd1 <<< (w - 1)))
      v = v - (64'sd1 <<< w);
`ifdef EXT_SHIFT_EN
    if (sh) v = v * 4;
`else
    if (sh) v = v;
`endif
    return 32'(v);
  endfunction

  task automatic drive(input logic [22:0] d, input logic [1:0] m,
                       input logic sh, input logic [31:0] e,
                       output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_shift = sh;
    waits    = 0;
    forever begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        sb_q.push_back(e);
        break;
      end
      waits++;
      if (waits > 100) begin
        chk("push_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 23'($urandom);
    in_mode  = 2'($urandom);
    in_shift = 1'($urandom);
  endtask

  // Monitor: occupancy-based expectations, then data on pop.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        sb_q.delete();
      end else begin
        chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
        if (out_valid && out_ready && sb_q.size() != 0)
          chk("out_data", out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    int total;
    logic [22:0] d;
    logic [1:0]  m;
    logic        sh;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    drive(23'h040000, 2'b00, 1'b0, 32'hFFFC0000, w);
    drive(23'h400000, 2'b01, 1'b0, 32'hFFC00000, w);
    drive(23'h400000, 2'b11, 1'b0, 32'h00400000, w);
    drive(23'h7FFFFF, 2'b10, 1'b0, 32'h0007FFFF, w);
    drive(23'h7FFFFF, 2'b00, 1'b0, 32'hFFFFFFFF, w);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back into a stalled output: third push must wait.
    out_ready = 1'b0;
    fork
      begin
        drive(23'h000001, 2'b10, 1'b0, 32'h00000001, w);
        drive(23'h000002, 2'b10, 1'b0, 32'h00000002, w);
        drive(23'h000003, 2'b10, 1'b0, 32'h00000003, w);
        chk("third_push_waited", 32'(w > 0), 32'd1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Streaming: every push lands without waiting.
    total = 0;
    for (int i = 0; i < 8; i++) begin
      d = 23'($urandom);
      m = 2'($urandom);
      drive(d, m, 1'b0, model(d, m, 1'b0), w);
      total += w;
    end
    chk("stream_no_stall", 32'(total), 32'd0);
    repeat (4) @(posedge clk);
    #1;

`ifdef EXT_SHIFT_EN
    drive(23'h7FFFFF, 2'b01, 1'b1, 32'hFFFFFFFC, w);
    drive(23'h7FFFFF, 2'b01, 1'b0, 32'hFFFFFFFF, w);
    repeat (3) @(posedge clk);
    #1;
`endif

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d  = 23'($urandom);
      m  = 2'($urandom);
`ifdef EXT_SHIFT_EN
      sh = 1'($urandom);
`else
      sh = 1'b0;
`endif
      drive(d, m, sh, model(d, m, sh), w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drained", 32'(sb_q.size()), 32'd0);

    // Fill to two entries, then reset mid-operation.
    out_ready = 1'b0;
    drive(23'h0000AA, 2'b10, 1'b0, 32'h000000AA, w);
    drive(23'h0000BB, 2'b10, 1'b0, 32'h000000BB, w);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_out", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
